dtw_systarr_gen: RTL
====================

DTW_SYSTARR_GEN -- requirements
Module: dtw_systarr_gen

Interface
REQ-001 Parameter N_PE, default 6: number of processing lanes, 2..16.
REQ-002 Parameter FEAT_W, default 30: feature sample width, unsigned.
REQ-003 Parameter IDX_W, default 5: sample index width.
REQ-004 Parameter DIST_W, default 16: accumulated distance width, unsigned.
REQ-005 Port clk  in  1: single clock, rising edge.
REQ-006 Port nrst  in  1: reset, synchronous, active-low.
REQ-007 Port ena  in  1: global advance; when 0, all registers hold.
REQ-008 Port start  in  1: request a wavefront run; sampled in IDLE only.
REQ-009 Port seq_len  in  IDX_W: number of R samples per run.
REQ-010 Port t_in/t_idx_in  in  FEAT_W/IDX_W: new T sample and its index.
REQ-011 Port t_load  in  N_PE: per lane, 1 = load t_in, 0 = take upstream neighbour.
REQ-012 Port r_in/r_idx_in/r_load  in  FEAT_W/IDX_W/N_PE: same as T, for R.
REQ-013 Port d0/d1/d2  in  N_PE*DIST_W: per-lane predecessor distances (diagonal/up/left); lane 0 in the MS slice.
REQ-014 Port d_out  out  N_PE*DIST_W: per-lane accumulated distance.
REQ-015 Port path  out  N_PE*2: per-lane predecessor code.
REQ-016 Port t_idx_out/r_idx_out  out  N_PE*IDX_W: index currently held per lane.
REQ-017 Port lane_vld  out  N_PE: lane output holds a valid cell this step.
REQ-018 Port busy/done  out  1/1: run in progress / one-cycle end-of-run pulse.

Function
REQ-019 T shifts lane N_PE-1 toward lane 0; lane N_PE-1's upstream is zero (value and index).
REQ-020 R shifts lane 0 toward lane N_PE-1; lane 0's upstream is zero (value and index).
REQ-021 Per lane: cost = |T - R|, clamped to 2^DIST_W-1 if wider.
REQ-022 Per lane: m = min(d0,d1,d2); tie priority d0 > d1 > d2; path = 00 (d0), 01 (d1), 10 (d2); 11 never emitted.
REQ-023 Per lane: d_out = cost + m; all outputs registered, latency exactly 1 ena=1 cycle from input sampling.
REQ-024 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1 with ena=1 and seq_len!=0; start with seq_len=0 -> DONE directly.
REQ-025 In RUN, a step counter s counts 0..seq_len+N_PE-2, incrementing on each ena=1 cycle; RUN->DONE after the last step.
REQ-026 lane_vld[k] registered alongside d_out: 1 iff s >= k and s-k < seq_len for the step sampled.
REQ-027 DONE lasts one cycle with done=1, then IDLE; busy=1 in RUN and DONE.
REQ-028 start in RUN or DONE is ignored; ena=0 in any state freezes s, state, and outputs.
REQ-029 Outside RUN, datapath still advances on ena but lane_vld=0.

Reset
REQ-030 nrst=0 at a clock edge: state IDLE, s=0, d_out/path/indices/T/R registers 0, lane_vld=0, busy=0, done=0, regardless of ena.
REQ-031 Reset mid-run abandons the run; no done pulse is produced.

Configuration
REQ-032 Macro DTW_SAT_EN defined: cost+m saturates at 2^DIST_W-1.
REQ-033 Macro DTW_SAT_EN undefined: cost+m wraps modulo 2^DIST_W; cost clamp of REQ-021 still applies.

Structure
REQ-034 Shared package dtw_pkg holds path codes (PATH_DIAG=00, PATH_UP=01, PATH_LEFT=10), FSM state encoding, and default parameter constants.
REQ-035 One sub-module dtw_pe (one lane: shift regs, cost, min, add, path); top holds generate loop, FSM, counter, lane_vld.

Verification
REQ-036 Reset: nrst=0 for 2 cycles with ena=1 and random inputs -> all outputs 0, busy=0.
REQ-037 Single lane: T=10, R=3, d0=5, d1=5, d2=9 -> next cycle d_out=12, path=00 (tie to d0).
REQ-038 Saturation, DIST_W=16, DTW_SAT_EN: cost=2, d0=d1=d2=16'hFFFE -> d_out=16'hFFFF; without the macro -> 16'h0000.
REQ-039 Wavefront, N_PE=6, seq_len=4, ena=1: busy for 10 cycles total, done pulses once, lane_vld[0] high steps 0..3, lane_vld[5] high steps 5..8.
REQ-040 Stall: ena=0 for 3 cycles mid-run -> s, outputs, and lane_vld unchanged; run completes 3 cycles late.
REQ-041 Edge cases: start with seq_len=0 -> done after 1 cycle, lane_vld never set; start during RUN -> ignored.

Source files
------------

// File: rtl/dtw_pkg.sv
// Shared constants for the DTW systolic array: path codes, FSM states,
// default parameter values.
package dtw_pkg;

  localparam logic [1:0] PATH_DIAG = 2'b00;
  localparam logic [1:0] PATH_UP   = 2'b01;
  localparam logic [1:0] PATH_LEFT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DEF_N_PE   = 6;
  localparam int DEF_FEAT_W = 30;
  localparam int DEF_IDX_W  = 5;
  localparam int DEF_DIST_W = 16;

endpackage

// File: rtl/dtw_pe.sv
// One DTW lane: T/R shift registers, |T-R| cost (clamped), min-of-three
// predecessor with path code, registered d = cost + min.
// Ports: i_t_*/i_r_* new/upstream samples + load selects, i_d0..2
// predecessor distances, o_* registered lane state and results.
// Build macro DTW_SAT_EN: saturate cost+min instead of wrapping.
module dtw_pe
  import dtw_pkg::*;
#(
  parameter int FEAT_W = DEF_FEAT_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DIST_W = DEF_DIST_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_ena,
  input  logic [FEAT_W-1:0] i_t_in,
  input  logic [FEAT_W-1:0] i_t_up,
  input  logic [IDX_W-1:0]  i_t_idx_in,
  input  logic [IDX_W-1:0]  i_t_idx_up,
  input  logic              i_t_load,
  input  logic [FEAT_W-1:0] i_r_in,
  input  logic [FEAT_W-1:0] i_r_up,
  input  logic [IDX_W-1:0]  i_r_idx_in,
  input  logic [IDX_W-1:0]  i_r_idx_up,
  input  logic              i_r_load,
  input  logic [DIST_W-1:0] i_d0,
  input  logic [DIST_W-1:0] i_d1,
  input  logic [DIST_W-1:0] i_d2,
  output logic [FEAT_W-1:0] o_t,
  output logic [IDX_W-1:0]  o_t_idx,
  output logic [FEAT_W-1:0] o_r,
  output logic [IDX_W-1:0]  o_r_idx,
  output logic [DIST_W-1:0] o_d,
  output logic [1:0]        o_path
);

  localparam int MW = (FEAT_W > DIST_W) ? FEAT_W : DIST_W;

  logic [FEAT_W-1:0] r_t, r_r;
  logic [IDX_W-1:0]  r_t_idx, r_r_idx;
  logic [DIST_W-1:0] r_d;
  logic [1:0]        r_path;

  logic [FEAT_W-1:0] w_t, w_r, w_diff;
  logic [IDX_W-1:0]  w_t_idx, w_r_idx;
  logic [MW-1:0]     w_diff_x, w_dmax;
  logic [DIST_W-1:0] w_cost, w_min, w_d;
  logic [1:0]        w_path;

  // Cost uses the samples entering the lane this cycle, so d_out
  // lines up with the indices registered in the same edge.
  assign w_t     = i_t_load ? i_t_in : i_t_up;
  assign w_t_idx = i_t_load ? i_t_idx_in : i_t_idx_up;
  assign w_r     = i_r_load ? i_r_in : i_r_up;
  assign w_r_idx = i_r_load ? i_r_idx_in : i_r_idx_up;

  assign w_diff   = (w_t >= w_r) ? (w_t - w_r) : (w_r - w_t);
  assign w_diff_x = MW'(w_diff);
  assign w_dmax   = MW'({DIST_W{1'b1}});
  assign w_cost   = (w_diff_x > w_dmax) ? {DIST_W{1'b1}}
                                        : w_diff_x[DIST_W-1:0];

  // Strict compares give the d0 > d1 > d2 tie priority.
  always_comb begin
    w_min  = i_d0;
    w_path = PATH_DIAG;
    if (i_d1 < w_min) begin
      w_min  = i_d1;
      w_path = PATH_UP;
    end
    if (i_d2 < w_min) begin
      w_min  = i_d2;
      w_path = PATH_LEFT;
    end
  end

`ifdef DTW_SAT_EN
  logic [DIST_W:0] w_sum;
  assign w_sum = {1'b0, w_cost} + {1'b0, w_min};
  assign w_d   = w_sum[DIST_W] ? {DIST_W{1'b1}} : w_sum[DIST_W-1:0];
`else
  assign w_d = w_cost + w_min;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_t     <= '0;
      r_t_idx <= '0;
      r_r     <= '0;
      r_r_idx <= '0;
      r_d     <= '0;
      r_path  <= PATH_DIAG;
    end else if (i_ena) begin
      r_t     <= w_t;
      r_t_idx <= w_t_idx;
      r_r     <= w_r;
      r_r_idx <= w_r_idx;
      r_d     <= w_d;
      r_path  <= w_path;
    end
  end

  assign o_t     = r_t;
  assign o_t_idx = r_t_idx;
  assign o_r     = r_r;
  assign o_r_idx = r_r_idx;
  assign o_d     = r_d;
  assign o_path  = r_path;

endmodule

// File: rtl/dtw_systarr_gen.sv
// DTW wavefront systolic array: N_PE lanes, run FSM, step counter, lane_vld.
// Multi-bit per-lane buses carry lane 0 in the MS slice; N_PE-wide
// vectors (t_load, r_load, lane_vld) use bit k for lane k.
// Build macro DTW_SAT_EN: saturating distance accumulate (else wrap).
module dtw_systarr_gen
  import dtw_pkg::*;
#(
  parameter int N_PE   = DEF_N_PE,
  parameter int FEAT_W = DEF_FEAT_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DIST_W = DEF_DIST_W
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   ena,
  input  logic                   start,
  input  logic [IDX_W-1:0]       seq_len,
  input  logic [FEAT_W-1:0]      t_in,
  input  logic [IDX_W-1:0]       t_idx_in,
  input  logic [N_PE-1:0]        t_load,
  input  logic [FEAT_W-1:0]      r_in,
  input  logic [IDX_W-1:0]       r_idx_in,
  input  logic [N_PE-1:0]        r_load,
  input  logic [N_PE*DIST_W-1:0] d0,
  input  logic [N_PE*DIST_W-1:0] d1,
  input  logic [N_PE*DIST_W-1:0] d2,
  output logic [N_PE*DIST_W-1:0] d_out,
  output logic [N_PE*2-1:0]      path,
  output logic [N_PE*IDX_W-1:0]  t_idx_out,
  output logic [N_PE*IDX_W-1:0]  r_idx_out,
  output logic [N_PE-1:0]        lane_vld,
  output logic                   busy,
  output logic                   done
);

  localparam int S_W = IDX_W + 5;

  logic [FEAT_W-1:0] w_t[N_PE], w_r[N_PE];
  logic [FEAT_W-1:0] w_t_up[N_PE], w_r_up[N_PE];
  logic [IDX_W-1:0]  w_ti[N_PE], w_ri[N_PE];
  logic [IDX_W-1:0]  w_ti_up[N_PE], w_ri_up[N_PE];

  for (genvar k = 0; k < N_PE; k++) begin : g_lane
    localparam int MS = N_PE - 1 - k;
    if (k == N_PE - 1) begin : g_t_end
      assign w_t_up[k]  = '0;
      assign w_ti_up[k] = '0;
    end else begin : g_t_mid
      assign w_t_up[k]  = w_t[k+1];
      assign w_ti_up[k] = w_ti[k+1];
    end
    if (k == 0) begin : g_r_end
      assign w_r_up[k]  = '0;
      assign w_ri_up[k] = '0;
    end else begin : g_r_mid
      assign w_r_up[k]  = w_r[k-1];
      assign w_ri_up[k] = w_ri[k-1];
    end
    dtw_pe #(
      .FEAT_W(FEAT_W),
      .IDX_W (IDX_W),
      .DIST_W(DIST_W)
    ) u_pe (
      .clk       (clk),
      .nrst      (nrst),
      .i_ena     (ena),
      .i_t_in    (t_in),
      .i_t_up    (w_t_up[k]),
      .i_t_idx_in(t_idx_in),
      .i_t_idx_up(w_ti_up[k]),
      .i_t_load  (t_load[k]),
      .i_r_in    (r_in),
      .i_r_up    (w_r_up[k]),
      .i_r_idx_in(r_idx_in),
      .i_r_idx_up(w_ri_up[k]),
      .i_r_load  (r_load[k]),
      .i_d0      (d0[MS*DIST_W +: DIST_W]),
      .i_d1      (d1[MS*DIST_W +: DIST_W]),
      .i_d2      (d2[MS*DIST_W +: DIST_W]),
      .o_t       (w_t[k]),
      .o_t_idx   (w_ti[k]),
      .o_r       (w_r[k]),
      .o_r_idx   (w_ri[k]),
      .o_d       (d_out[MS*DIST_W +: DIST_W]),
      .o_path    (path[MS*2 +: 2])
    );
    assign t_idx_out[MS*IDX_W +: IDX_W] = w_ti[k];
    assign r_idx_out[MS*IDX_W +: IDX_W] = w_ri[k];
  end

  state_t          r_state;
  logic [S_W-1:0]  r_s;
  logic [IDX_W-1:0] r_len;
  logic            r_busy, r_done;
  logic [N_PE-1:0] r_vld;
  logic [N_PE-1:0] w_vld;
  logic            w_last;

  assign w_last = (r_s == S_W'(r_len) + S_W'(N_PE - 2));

  // Lane k works on R sample s-k at step s.
  always_comb begin
    w_vld = '0;
    for (int k = 0; k < N_PE; k++) begin
      w_vld[k] = (r_s >= S_W'(k)) &&
                 ((r_s - S_W'(k)) < S_W'(r_len));
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_len   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_vld   <= '0;
    end else if (ena) begin
      r_vld  <= '0;
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len  <= seq_len;
            r_s    <= '0;
            r_busy <= 1'b1;
            if (seq_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_vld <= w_vld;
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_s     <= '0;
          end else begin
            r_s <= r_s + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign lane_vld = r_vld;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
